// File: rtl/div23_seq.sv
// ---------------------------------------------------------------------------
// div23_seq
//   Digit-serial unsigned divide of a 16-bit dividend by the constant 23.
//   Every RUN cycle consumes CHUNK dividend bits (MSB first). It forms
//   p = r*2^CHUNK + d and resolves one CHUNK-bit quotient digit plus the next
//   remainder. A compare/subtract ladder against 23<<b does this.
//
// Parameters
//   CHUNK      dividend bits per cycle: 1, 2, 4 or 8
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   dividend offered
//   in_ready   block idle and out of reset (combinational from state)
//   in_data    16-bit unsigned dividend
//   out_valid  quot/rem hold a finished result
//   out_ready  consumer takes the result
//   quot       floor(in_data / 23)
//   rem        in_data mod 23
//   busy       high for the 16/CHUNK RUN cycles
// ---------------------------------------------------------------------------
module div23_seq #(
    parameter int CHUNK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quot,
    output logic [4:0]  rem,
    output logic        busy
);

    localparam int STEPS = 16 / CHUNK;
    localparam int PW    = 5 + CHUNK;   // width of the partial value p

    generate
        if (!(CHUNK == 1 || CHUNK == 2 || CHUNK == 4 || CHUNK == 8)) begin : g_bad_chunk
            $error("div23_seq: CHUNK must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [15:0] quot_q;
    logic [4:0]  rem_q;     // doubles as the running remainder during RUN
    logic [4:0]  cnt_q;
    logic        out_valid_q;
    logic        busy_q;

    // One digit step. Because p < 23*2^CHUNK, each rung sees
    // t < 23*2^(b+1), so a single conditional subtract per bit is exact.
    logic [CHUNK-1:0] dig;
    logic [PW-1:0]    p;
    logic [PW-1:0]    t;
    logic [CHUNK-1:0] qd_d;
    logic [4:0]       r_d;

    always_comb begin
        dig  = shift_q[15 -: CHUNK];
        p    = {rem_q, dig};
        t    = p;
        qd_d = '0;
        for (int b = CHUNK - 1; b >= 0; b--) begin
            if (t >= (PW'(23) << b)) begin
                t       = t - (PW'(23) << b);
                qd_d[b] = 1'b1;
            end
        end
        r_d = 5'(t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shift_q <= in_data;
                        quot_q  <= '0;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    quot_q  <= {quot_q[15-CHUNK:0], qd_d};
                    shift_q <= shift_q << CHUNK;
                    rem_q   <= r_d;
                    cnt_q   <= cnt_q + 5'd1;
                    if (cnt_q == 5'(STEPS - 1)) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result is held. Accepting the next dividend waits one
                    // IDLE cycle (no bypass).
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign quot      = quot_q;
    assign rem       = rem_q;

endmodule

// File: doc/div23_seq.md
# div23_seq

Sequential, digit-serial divider of a 16-bit unsigned dividend by the constant 23. It sits directly upstream of the per-chunk quotient lookup stages. Each cycle it forms the partial value (running remainder × 2^CHUNK + next dividend chunk) and resolves one quotient digit and the next remainder. It presents the full quotient and final remainder to the consumer under a valid/ready handshake.

## Interface
- `CHUNK`, default 4: dividend bits consumed per cycle, MSB first.
  - Legal values: 1, 2, 4, 8.
  - Any other value is a compile-time error.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: dividend offered.
- `in_ready`  output  1: block can accept a dividend.
- `in_data`  input  16: unsigned dividend.
- `out_valid`  output  1: result available.
- `out_ready`  input  1: consumer accepts result.
- `quot`  output  16: floor(in_data / 23).
- `rem`  output  5: in_data mod 23, range 0..22.
- `busy`  output  1: high while in RUN.

## Operation
- States: IDLE, RUN, DONE.
  - Reset state is IDLE.
  - Encoding is free.
- Reset values, applied asynchronously while `rst_n`=0:
  - `out_valid`=0, `busy`=0, `quot`=0, `rem`=0.
  - Step counter and dividend shift register = 0.
- `in_ready` = (state==IDLE) and `rst_n`=1. It is combinational from state.
- **IDLE**
  - On `in_valid`&`in_ready`: latch `in_data` into the shift register, clear the running remainder r=0, clear the quotient register and the step counter, then go to RUN.
  - `in_data` is ignored otherwise.
- **RUN**, performed once per cycle:
  - d = top CHUNK bits of the shift register.
  - p = r·2^CHUNK + d. Width is 5+CHUNK bits; p < 23·2^CHUNK.
  - qd = floor(p/23). Width is CHUNK bits; qd < 2^CHUNK always.
  - r ← p − 23·qd, which is always < 23.
  - Quotient register ← {quotient[15−CHUNK:0], qd}.
  - Shift register ← shift register << CHUNK.
- The RUN step is pure combinational logic of p. Any exact realisation is allowed: compare/subtract ladder or case table. No generic divider.
- After 16/CHUNK RUN cycles, go to DONE. In DONE, `quot` and `rem` hold the final values.
- **DONE**
  - `out_valid`=1.
  - `quot` and `rem` stay stable until the handshake `out_valid`&`out_ready`, then go to IDLE.
  - `quot` and `rem` keep their values in IDLE until the next accept. `out_valid` drops to 0.
- There is no bypass. A new dividend cannot be accepted in the same cycle a result is consumed. `in_ready` rises the cycle after the DONE handshake.
- `in_valid` during RUN or DONE has no effect. The upstream must hold its data until `in_ready`.
- Reset asserted mid-RUN or mid-DONE:
  - Immediately abandon the operation and return to IDLE with reset values.
  - No partial result is ever flagged valid.
- All arithmetic is unsigned. Intermediate p never exceeds 367 (CHUNK=4) or 5887 (CHUNK=8).

## Timing
- Accept at rising edge N puts the block in RUN from N.
- RUN steps occur at edges N+1 … N+16/CHUNK.
- `out_valid` is high from edge N+16/CHUNK: after 4 edges for CHUNK=4, 16 edges for CHUNK=1.
- Result-to-next-accept: at least 1 IDLE cycle.
  - Throughput with `out_ready` tied high is one dividend per 16/CHUNK+2 cycles.
- `busy`=1 exactly in the 16/CHUNK cycles spent in RUN.
- All outputs except `in_ready` are registered.

## Test plan
- Reset then `in_data`=0xFFFF, CHUNK=4, `out_ready`=1 → `out_valid` 4 cycles after accept, `quot`=2849 (0x0B21), `rem`=8.
- Edge values 0, 22, 23, 1000 back-to-back → (0,0), (0,22), (1,0), (43,11). Check that `in_ready` reasserts one cycle after each consume.
- Backpressure: `out_ready`=0 for 10 cycles in DONE with `in_valid`=1 and new `in_data` → `quot`/`rem` stable, `in_ready`=0, new data not taken until after the handshake.
- Reset pulse (`rst_n`=0 for 1 cycle) in the 2nd RUN cycle → `out_valid` never asserts for that operation. All outputs return to reset values asynchronously. The next dividend 46 yields (2,0).
- Exhaustive 0..65535 with a random `out_ready` pattern against the golden model floor(x/23), x mod 23, for CHUNK=1, 2, 4, 8. Latency must be 16/CHUNK every time.
